// File: rtl/ramb_asym_dp.sv
// rtl/ramb_asym_dp.sv - dual-port block RAM with asymmetric port widths
//
// Port A reads/writes WIDTH_A-bit words; port B reads/writes RATIO_B adjacent
// A words as one WIDTH_B-bit word (lane 0 = lowest A address = LSBs).
//
// Ports:
//   CLK          single clock, rising edge
//   RST_N        synchronous active-low reset of output stages and COLL only
//   ENA/WEA      port A enable / write enable (WEA qualified by ENA)
//   ADDRA/DIA    port A word address / write data
//   DOA          port A read data (1 or 2 cycle latency, see DO_REG_A)
//   ENB/WEB      port B enable / write enable (WEB qualified by ENB)
//   ADDRB/DIB    port B word address / write data
//   DOB          port B read data (1 or 2 cycle latency, see DO_REG_B)
//   COLL         one-cycle pulse after a same-word access where a port wrote
module ramb_asym_dp #(
  parameter int                            WIDTH_A      = 16,
  parameter int                            RATIO_B      = 2,
  parameter int                            DEPTH_A      = 1024,
  parameter string                         WRITE_MODE_A = "WRITE_FIRST",
  parameter string                         WRITE_MODE_B = "WRITE_FIRST",
  parameter int                            DO_REG_A     = 0,
  parameter int                            DO_REG_B     = 0,
  parameter logic [WIDTH_A-1:0]            SRVAL_A      = '0,
  parameter logic [WIDTH_A*RATIO_B-1:0]    SRVAL_B      = '0
) (
  input  logic                                          CLK,
  input  logic                                          RST_N,
  input  logic                                          ENA,
  input  logic                                          WEA,
  input  logic [$clog2(DEPTH_A)-1:0]                    ADDRA,
  input  logic [WIDTH_A-1:0]                            DIA,
  output logic [WIDTH_A-1:0]                            DOA,
  input  logic                                          ENB,
  input  logic                                          WEB,
  input  logic [$clog2(DEPTH_A)-$clog2(RATIO_B)-1:0]    ADDRB,
  input  logic [WIDTH_A*RATIO_B-1:0]                    DIB,
  output logic [WIDTH_A*RATIO_B-1:0]                    DOB,
  output logic                                          COLL
);

  localparam int AW_A    = $clog2(DEPTH_A);
  localparam int LR      = $clog2(RATIO_B);
  localparam int AW_B    = AW_A - LR;
  localparam int WIDTH_B = WIDTH_A * RATIO_B;

  localparam int MODE_WF = 0;
  localparam int MODE_RF = 1;
  localparam int MODE_NC = 2;

  localparam int MODE_A = (WRITE_MODE_A == "READ_FIRST") ? MODE_RF :
                          (WRITE_MODE_A == "NO_CHANGE")  ? MODE_NC : MODE_WF;
  localparam int MODE_B = (WRITE_MODE_B == "READ_FIRST") ? MODE_RF :
                          (WRITE_MODE_B == "NO_CHANGE")  ? MODE_NC : MODE_WF;

  logic [WIDTH_A-1:0] r_mem [DEPTH_A];

  logic [WIDTH_A-1:0] r_lat_a;
  logic [WIDTH_B-1:0] r_lat_b;
  logic               r_coll;

  logic               w_wr_a;
  logic               w_wr_b;
  logic               w_overlap;
  logic [AW_A-1:0]    w_base_b;
  logic [WIDTH_A-1:0] w_rda;
  logic [WIDTH_B-1:0] w_rdb;

  assign w_wr_a    = ENA && WEA;
  assign w_wr_b    = ENB && WEB;
  // First A word covered by the B word.
  assign w_base_b  = AW_A'(ADDRB) << LR;
  assign w_overlap = ENA && ENB && (AW_B'(ADDRA >> LR) == ADDRB);

  // Combinational reads see contents before this edge's writes, which gives
  // READ_FIRST data and pre-write data for the reading side of a collision.
  assign w_rda = r_mem[ADDRA];

  always_comb begin
    w_rdb = '0;
    for (int i = 0; i < RATIO_B; i++) begin
      w_rdb[i*WIDTH_A +: WIDTH_A] = r_mem[w_base_b + AW_A'(i)];
    end
  end

  // Memory array has no reset; writes during reset still commit.
  // When both ports write the shared word, port A is suppressed so B wins.
  always_ff @(posedge CLK) begin
    if (w_wr_a && !(w_overlap && w_wr_b)) begin
      r_mem[ADDRA] <= DIA;
    end
    if (w_wr_b) begin
      for (int i = 0; i < RATIO_B; i++) begin
        r_mem[w_base_b + AW_A'(i)] <= DIB[i*WIDTH_A +: WIDTH_A];
      end
    end
  end

  // Port A first-stage output latch.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_lat_a <= SRVAL_A;
    end else if (ENA) begin
      if (!WEA) begin
        r_lat_a <= w_rda;
      end else if (MODE_A == MODE_WF) begin
        r_lat_a <= DIA;
      end else if (MODE_A == MODE_RF) begin
        r_lat_a <= w_rda;
      end
    end
  end

  // Port B first-stage output latch.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_lat_b <= SRVAL_B;
    end else if (ENB) begin
      if (!WEB) begin
        r_lat_b <= w_rdb;
      end else if (MODE_B == MODE_WF) begin
        r_lat_b <= DIB;
      end else if (MODE_B == MODE_RF) begin
        r_lat_b <= w_rdb;
      end
    end
  end

  // Optional output pipeline stages load every cycle regardless of enable.
  generate
    if (DO_REG_A != 0) begin : g_reg_a
      logic [WIDTH_A-1:0] r_pipe_a;
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          r_pipe_a <= SRVAL_A;
        end else begin
          r_pipe_a <= r_lat_a;
        end
      end
      assign DOA = r_pipe_a;
    end else begin : g_noreg_a
      assign DOA = r_lat_a;
    end

    if (DO_REG_B != 0) begin : g_reg_b
      logic [WIDTH_B-1:0] r_pipe_b;
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          r_pipe_b <= SRVAL_B;
        end else begin
          r_pipe_b <= r_lat_b;
        end
      end
      assign DOB = r_pipe_b;
    end else begin : g_noreg_b
      assign DOB = r_lat_b;
    end
  endgenerate

  // Collision flag: any same-word overlap with at least one writer.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_overlap && (WEA || WEB);
    end
  end

  assign COLL = r_coll;

endmodule

// File: tb/tb_ramb_asym_dp.sv
// tb/tb_ramb_asym_dp.sv - scoreboard bench for ramb_asym_dp across write modes and pipeline options
module tb_ramb_asym_dp;

  localparam logic [15:0] SRV_A = 16'h00AA;
  localparam logic [31:0] SRV_B = 32'h0000BB00;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
  logic [9:0]  addra = '0;
  logic [8:0]  addrb = '0;
  logic [15:0] dia = '0;
  logic [31:0] dib = '0;

  logic [15:0] doa  [3];
  logic [31:0] dob  [3];
  logic        coll [3];

  // d0: WRITE_FIRST, no pipeline
  ramb_asym_dp #(.WIDTH_A(16), .RATIO_B(2), .DEPTH_A(1024),
                 .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
                 .DO_REG_A(0), .DO_REG_B(0), .SRVAL_A(SRV_A), .SRVAL_B(SRV_B)) d0 (
    .CLK(clk), .RST_N(rst_n), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[0]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[0]), .COLL(coll[0]));

  // d1: READ_FIRST, both ports pipelined
  ramb_asym_dp #(.WIDTH_A(16), .RATIO_B(2), .DEPTH_A(1024),
                 .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
                 .DO_REG_A(1), .DO_REG_B(1), .SRVAL_A(SRV_A), .SRVAL_B(SRV_B)) d1 (
    .CLK(clk), .RST_N(rst_n), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[1]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[1]), .COLL(coll[1]));

  // d2: NO_CHANGE, only port B pipelined
  ramb_asym_dp #(.WIDTH_A(16), .RATIO_B(2), .DEPTH_A(1024),
                 .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("NO_CHANGE"),
                 .DO_REG_A(0), .DO_REG_B(1), .SRVAL_A(SRV_A), .SRVAL_B(SRV_B)) d2 (
    .CLK(clk), .RST_N(rst_n), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[2]),
    .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[2]), .COLL(coll[2]));

  typedef struct packed {
    logic [2:0][15:0] a;
    logic [2:0][31:0] b;
    logic             c;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: flat array of A words plus each instance's visible output stages.
  logic [15:0] m_mem    [1024];
  logic [15:0] m_lat_a  [3];
  logic [15:0] m_pipe_a [3];
  logic [31:0] m_lat_b  [3];
  logic [31:0] m_pipe_b [3];

  // Instance k: mode 0=write-first 1=read-first 2=no-change.
  function automatic bit piped_a(input int k); return k == 1; endfunction
  function automatic bit piped_b(input int k); return k >= 1; endfunction

  task automatic step(input logic r, input logic ea, input logic wa, input logic [9:0] aa,
                      input logic [15:0] da, input logic eb, input logic wb,
                      input logic [8:0] ab, input logic [31:0] db);
    exp_t        e;
    logic [15:0] ra;
    logic [31:0] rb;
    logic        ov;
    int          wa_idx;
    int          lo_idx;
    @(negedge clk);
    rst_n = r; ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;

    wa_idx = int'(aa);
    lo_idx = int'(ab) * 2;
    ra = m_mem[wa_idx];
    rb = {m_mem[lo_idx + 1], m_mem[lo_idx]};
    ov = ea && eb && (int'(aa) / 2 == int'(ab));
    e.c = r && ov && (wa || wb);

    for (int k = 0; k < 3; k++) begin
      m_pipe_a[k] = r ? m_lat_a[k] : SRV_A;
      m_pipe_b[k] = r ? m_lat_b[k] : SRV_B;
      if (!r) begin
        m_lat_a[k] = SRV_A;
        m_lat_b[k] = SRV_B;
      end else begin
        if (ea) begin
          if (!wa)        m_lat_a[k] = ra;
          else if (k == 0) m_lat_a[k] = da;
          else if (k == 1) m_lat_a[k] = ra;
        end
        if (eb) begin
          if (!wb)        m_lat_b[k] = rb;
          else if (k == 0) m_lat_b[k] = db;
          else if (k == 1) m_lat_b[k] = rb;
        end
      end
      e.a[k] = piped_a(k) ? m_pipe_a[k] : m_lat_a[k];
      e.b[k] = piped_b(k) ? m_pipe_b[k] : m_lat_b[k];
    end

    if (ea && wa && !(ov && wb)) m_mem[wa_idx] = da;
    if (eb && wb) begin
      m_mem[lo_idx]     = db[15:0];
      m_mem[lo_idx + 1] = db[31:16];
    end
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0, 1'b0, 9'h0, 32'h0);
  endtask

  task automatic rd_a(input logic [9:0] aa);
    step(1'b1, 1'b1, 1'b0, aa, 16'h0, 1'b0, 1'b0, 9'h0, 32'h0);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: every edge that consumed a stimulus cycle has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
          total += 3;
          if (doa[k] !== e.a[k]) begin
            bad++;
            $display("FAIL sb_doa d%0d @%0t: got %h want %h", k, $time, doa[k], e.a[k]);
          end
          if (dob[k] !== e.b[k]) begin
            bad++;
            $display("FAIL sb_dob d%0d @%0t: got %h want %h", k, $time, dob[k], e.b[k]);
          end
          if (coll[k] !== e.c) begin
            bad++;
            $display("FAIL sb_coll d%0d @%0t: got %b want %b", k, $time, coll[k], e.c);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    for (int k = 0; k < 3; k++) begin
      m_lat_a[k] = '0; m_pipe_a[k] = '0; m_lat_b[k] = '0; m_pipe_b[k] = '0;
    end

    // Reset values
    step(1'b0, 1'b0, 1'b0, 10'h0, 16'h0, 1'b0, 1'b0, 9'h0, 32'h0);
    sample();
    chk("rst_doa", 32'(doa[0]), 32'h00AA);
    chk("rst_dob", dob[0], 32'h0000BB00);
    chk("rst_coll", 32'(coll[0]), 32'h0);
    chk("rst_dob_piped", dob[1], 32'h0000BB00);

    // Narrow writes, wide read
    step(1'b1, 1'b1, 1'b1, 10'h004, 16'hABCD, 1'b0, 1'b0, 9'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 10'h005, 16'h1234, 1'b0, 1'b0, 9'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b0, 9'h002, 32'h0);
    sample();
    chk("n2w_dob", dob[0], 32'h1234ABCD);

    // Wide write, narrow reads
    step(1'b1, 1'b0, 1'b0, 10'h0, 16'h0, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF);
    rd_a(10'h020);
    sample();
    chk("w2n_lo", 32'(doa[0]), 32'hBEEF);
    rd_a(10'h021);
    sample();
    chk("w2n_hi", 32'(doa[0]), 32'hDEAD);

    // Write modes
    step(1'b1, 1'b1, 1'b1, 10'h040, 16'h1111, 1'b0, 1'b0, 9'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 10'h041, 16'h0F0F, 1'b0, 1'b0, 9'h0, 32'h0);
    rd_a(10'h041);
    step(1'b1, 1'b1, 1'b1, 10'h040, 16'h2222, 1'b0, 1'b0, 9'h0, 32'h0);
    sample();
    chk("wm_write_first", 32'(doa[0]), 32'h2222);
    chk("wm_no_change", 32'(doa[2]), 32'h0F0F);
    idle();
    sample();
    chk("wm_read_first", 32'(doa[1]), 32'h1111);

    // Write/write collision: B wins the shared word
    step(1'b1, 1'b1, 1'b1, 10'h030, 16'h5555, 1'b1, 1'b1, 9'h018, 32'h77776666);
    sample();
    chk("coll_ww", 32'(coll[0]), 32'h1);
    rd_a(10'h030);
    sample();
    chk("coll_pulse_end", 32'(coll[0]), 32'h0);
    chk("coll_a030", 32'(doa[0]), 32'h6666);
    rd_a(10'h031);
    sample();
    chk("coll_a031", 32'(doa[0]), 32'h7777);

    // Back-to-back read/write collisions; A reads pre-write data
    step(1'b1, 1'b1, 1'b0, 10'h031, 16'h0, 1'b1, 1'b1, 9'h018, 32'h99998888);
    sample();
    chk("b2b_coll1", 32'(coll[0]), 32'h1);
    chk("rw_prewrite", 32'(doa[0]), 32'h7777);
    step(1'b1, 1'b1, 1'b0, 10'h030, 16'h0, 1'b1, 1'b1, 9'h018, 32'hBBBBAAAA);
    sample();
    chk("b2b_coll2", 32'(coll[0]), 32'h1);
    chk("rw_prewrite2", 32'(doa[0]), 32'h8888);
    step(1'b1, 1'b1, 1'b0, 10'h030, 16'h0, 1'b1, 1'b0, 9'h018, 32'h0);
    sample();
    chk("rr_no_coll", 32'(coll[0]), 32'h0);

    // Pipelined port A, then reset mid-pipeline
    rd_a(10'h020);
    idle();
    sample();
    chk("reg_lat2", 32'(doa[1]), 32'hBEEF);
    rd_a(10'h021);
    rd_a(10'h020);
    step(1'b0, 1'b1, 1'b1, 10'h050, 16'h4321, 1'b0, 1'b0, 9'h0, 32'h0);
    sample();
    chk("reg_rst_flush", 32'(doa[1]), 32'h00AA);
    idle();
    sample();
    chk("reg_rst_flush2", 32'(doa[1]), 32'h00AA);
    rd_a(10'h050);
    sample();
    chk("rst_write_commits", 32'(doa[0]), 32'h4321);

    // Randomized traffic in a small window so overlaps are frequent
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom), 1'($urandom), 10'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom), 1'($urandom), 9'($urandom_range(0, 7)), $urandom);
    end

    repeat (3) sample();
    chk("drain", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
